id_ex_stage: RTL and testbench

//  ID/EX pipeline register for the 5-stage MIPS, directly downstream of the main control decoder.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/load_use_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: opcodes, ALU op classes
// and the decoded control bundle carried from ID into EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dest;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(9'd0);

  // R-type, sw and beq read rt as a source; lw (immediate B operand) does not.
  function automatic logic uses_rt(ctrl_t c);
    return ~c.alu_src | c.mem_write | c.branch;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              haz
);

  logic rs_match_s;
  logic rt_match_s;

  assign rs_match_s = (ex_rt == id_rs);
  assign rt_match_s = id_uses_rt & (ex_rt == id_rt);

  // $0 is hardwired, so a load into it never creates a dependency
  assign haz = ex_valid & ex_mem_read & id_valid & (ex_rt != {REG_AW{1'b0}})
             & (rs_match_s | rt_match_s);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush squash and a
// saturating debug count of stall cycles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_dest,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_reg_dest,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t              id_ctrl_s;
  ctrl_t              ex_ctrl_r;
  logic               ex_valid_r;
  logic [DATA_W-1:0]  ex_rs_data_r;
  logic [DATA_W-1:0]  ex_rt_data_r;
  logic [DATA_W-1:0]  ex_imm_r;
  logic [REG_AW-1:0]  ex_rs_r;
  logic [REG_AW-1:0]  ex_rt_r;
  logic [REG_AW-1:0]  ex_rd_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               haz_s;
  logic               stall_s;

  assign id_ctrl_s = '{reg_dest:   id_reg_dest,
                       branch:     id_branch,
                       mem_read:   id_mem_read,
                       mem_to_reg: id_mem_to_reg,
                       mem_write:  id_mem_write,
                       alu_src:    id_alu_src,
                       reg_write:  id_reg_write,
                       alu_op:     id_alu_op};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid   (ex_valid_r),
    .ex_mem_read(ex_ctrl_r.mem_read),
    .ex_rt      (ex_rt_r),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (uses_rt(id_ctrl_s)),
    .haz        (haz_s)
  );

  // a taken branch discards the ID instruction, so its hazard is moot
  assign stall_s = haz_s & ~flush;

  // pipeline register: flush/stall load constant-zero control, otherwise capture ID
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_ctrl_r    <= CTRL_NOP;
      ex_rs_data_r <= {DATA_W{1'b0}};
      ex_rt_data_r <= {DATA_W{1'b0}};
      ex_imm_r     <= {DATA_W{1'b0}};
      ex_rs_r      <= {REG_AW{1'b0}};
      ex_rt_r      <= {REG_AW{1'b0}};
      ex_rd_r      <= {REG_AW{1'b0}};
    end else begin
      ex_rs_data_r <= id_rs_data;
      ex_rt_data_r <= id_rt_data;
      ex_imm_r     <= id_imm;
      ex_rs_r      <= id_rs;
      ex_rt_r      <= id_rt;
      ex_rd_r      <= id_rd;
      if (flush || stall_s) begin
        ex_valid_r <= 1'b0;
        ex_ctrl_r  <= CTRL_NOP;
      end else if (id_valid) begin
        ex_valid_r <= 1'b1;
        ex_ctrl_r  <= id_ctrl_s;
      end else begin
        ex_valid_r <= 1'b0;
        ex_ctrl_r  <= CTRL_NOP;
      end
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign ex_valid      = ex_valid_r;
  assign ex_reg_dest   = ex_ctrl_r.reg_dest;
  assign ex_branch     = ex_ctrl_r.branch;
  assign ex_mem_read   = ex_ctrl_r.mem_read;
  assign ex_mem_to_reg = ex_ctrl_r.mem_to_reg;
  assign ex_mem_write  = ex_ctrl_r.mem_write;
  assign ex_alu_src    = ex_ctrl_r.alu_src;
  assign ex_reg_write  = ex_ctrl_r.reg_write;
  assign ex_alu_op     = ex_ctrl_r.alu_op;
  assign ex_rs_data    = ex_rs_data_r;
  assign ex_rt_data    = ex_rt_data_r;
  assign ex_imm        = ex_imm_r;
  assign ex_rs         = ex_rs_r;
  assign ex_rt         = ex_rt_r;
  assign ex_rd         = ex_rd_r;
  assign stall         = stall_s;
  assign stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage (CNT_W=4 so counter saturation is reachable).
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  // control vector order: reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0]
  localparam logic [8:0] C_R   = 9'b1_0_0_0_0_0_1_10;
  localparam logic [8:0] C_LW  = 9'b0_0_1_1_0_1_1_00;
  localparam logic [8:0] C_SW  = 9'b0_0_0_0_1_1_0_00;
  localparam logic [8:0] C_BEQ = 9'b0_1_0_0_0_0_0_01;

  typedef struct {
    logic          valid;
    logic [8:0]    ctrl;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [CW-1:0] cnt;
    logic          chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, flush;
  logic [8:0] id_c;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic ex_valid, ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg;
  logic ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0] ex_alu_op;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic stall;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb_q[$];
  exp_t m;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg_dest(id_c[8]), .id_branch(id_c[7]), .id_mem_read(id_c[6]),
    .id_mem_to_reg(id_c[5]), .id_mem_write(id_c[4]), .id_alu_src(id_c[3]),
    .id_reg_write(id_c[2]), .id_alu_op(id_c[1:0]),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_dest(ex_reg_dest), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_ex(input exp_t e);
    logic [8:0] c;
    c = {ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
         ex_alu_src, ex_reg_write, ex_alu_op};
    chk("ex_valid", 64'(ex_valid), 64'(e.valid));
    chk("ex_ctrl", 64'(c), 64'(e.ctrl));
    chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
    if (e.chk_data) begin
      chk("ex_rs_data", 64'(ex_rs_data), 64'(e.rs_data));
      chk("ex_rt_data", 64'(ex_rt_data), 64'(e.rt_data));
      chk("ex_imm", 64'(ex_imm), 64'(e.imm));
      chk("ex_idx", 64'({ex_rs, ex_rt, ex_rd}), 64'({e.rs, e.rt, e.rd}));
    end
  endtask

  // n reset cycles; optionally randomise ID inputs meanwhile
  task automatic do_reset(input int n, input bit rnd);
    exp_t z;
    z = '{valid: 1'b0, ctrl: 9'd0, rs_data: '0, rt_data: '0, imm: '0,
          rs: '0, rt: '0, rd: '0, cnt: '0, chk_data: 1'b1};
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        id_valid = 1'($urandom); id_c = 9'($urandom); flush = 1'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      end
      sb_q.push_back(z);
      @(posedge clk); #1;
      compare_ex(sb_q.pop_front());
      m = z;
      chk("stall_in_rst", 64'(stall), 64'(1'b0));
    end
    rst = 1'b0;
  endtask

  // drive one ID slot, check comb. stall, predict and check the EX result
  task automatic step(input logic v, input logic [8:0] c, input logic [AW-1:0] rs,
                      input logic [AW-1:0] rt, input logic [AW-1:0] rd, input logic fl);
    exp_t nx;
    logic haz, urt, exp_stall;
    id_valid = v; id_c = c; flush = fl; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    #1;
    urt = ~c[3] | c[4] | c[7];
    haz = m.valid & m.ctrl[6] & v & (m.rt != 5'd0) & ((m.rt == rs) | (urt & (m.rt == rt)));
    exp_stall = haz & ~fl;
    chk("stall", 64'(stall), 64'(exp_stall));
    nx = m;
    if (fl || exp_stall) begin
      nx.valid = 1'b0; nx.ctrl = 9'd0; nx.chk_data = 1'b0;
    end else begin
      nx.valid = v; nx.ctrl = v ? c : 9'd0; nx.chk_data = 1'b1;
      nx.rs_data = id_rs_data; nx.rt_data = id_rt_data; nx.imm = id_imm;
    end
    nx.rs = rs; nx.rt = rt; nx.rd = rd;
    if (exp_stall && (nx.cnt != 4'd15)) nx.cnt = nx.cnt + 4'd1;
    sb_q.push_back(nx);
    @(posedge clk); #1;
    compare_ex(sb_q.pop_front());
    m = nx;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_c = 9'd0; flush = 1'b0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    do_reset(2, 1'b1);

    // R add $3,$1,$2
    step(1'b1, C_R, 5'd1, 5'd2, 5'd3, 1'b0);
    step(1'b0, C_R, 5'd0, 5'd0, 5'd0, 1'b0);   // invalid ID forces control to zero
    // lw $5,0($1) ; add $6,$5,$2 -> one stall then capture
    step(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    step(1'b1, C_R, 5'd5, 5'd2, 5'd6, 1'b0);
    chk("bubble_regwrite", 64'(ex_reg_write), 64'(1'b0));
    step(1'b1, C_R, 5'd5, 5'd2, 5'd6, 1'b0);
    // lw $5 ; lw with rt=5 -> rt not read, no stall
    step(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    step(1'b1, C_LW, 5'd9, 5'd5, 5'd0, 1'b0);
    // lw $0 ; use of $0 -> no stall
    step(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    step(1'b1, C_R, 5'd0, 5'd0, 5'd7, 1'b0);
    // lw $4 ; sw reading rt=4, and lw $8 ; beq reading rt=8 -> stalls
    step(1'b1, C_LW, 5'd1, 5'd4, 5'd0, 1'b0);
    step(1'b1, C_SW, 5'd2, 5'd4, 5'd0, 1'b0);
    step(1'b1, C_SW, 5'd2, 5'd4, 5'd0, 1'b0);
    step(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    step(1'b1, C_BEQ, 5'd3, 5'd8, 5'd0, 1'b0);
    step(1'b1, C_BEQ, 5'd3, 5'd8, 5'd0, 1'b0);
    // hazard together with flush -> no stall, bubble, count unchanged
    step(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    step(1'b1, C_R, 5'd5, 5'd2, 5'd6, 1'b1);
    // load into EX while ID is invalid -> no stall
    step(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    step(1'b0, C_R, 5'd5, 5'd5, 5'd6, 1'b0);
    // reset asserted while a stall is pending
    step(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    id_valid = 1'b1; id_c = C_R; id_rs = 5'd5; id_rt = 5'd2; id_rd = 5'd6; flush = 1'b0;
    #1;
    chk("stall_before_rst", 64'(stall), 64'(1'b1));
    do_reset(1, 1'b0);
    step(1'b1, C_R, 5'd5, 5'd2, 5'd6, 1'b0);
    // lw $5,0($5) repeatedly: stall every other cycle until saturation
    for (int i = 0; i < 40; i++) step(1'b1, C_LW, 5'd5, 5'd5, 5'd0, 1'b0);
    chk("cnt_saturated", 64'(stall_cnt), 64'(4'd15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
